reg_writeback: RTL and testbench

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback_pkg.sv | 41 ++++
 rtl/reg_writeback_load_align.sv | 70 +++++++
 rtl/reg_writeback.sv | 115 +++++++++++
 tb/tb_reg_writeback.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_pkg.sv
// -----------------------------------------------------------------------------
// reg_writeback_pkg
//   Shared core constants for the writeback stage: RV32 major opcodes, load
//   funct3 encodings, the writeback pipeline register layout and the
//   write-data source selector.
// -----------------------------------------------------------------------------
package reg_writeback_pkg;

    // RV32I major opcodes (inst[6:0]) that can write the register file.
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    // Load funct3 (inst[14:12]); 011, 110 and 111 are not legal loads.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Writeback pipeline register contents.
    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] alu;
    } wb_reg_t;

    // Where the register-file write data comes from.
    typedef enum logic [1:0] {
        WD_NONE,
        WD_ALU,
        WD_PC4,
        WD_LOAD
    } wd_sel_e;

endpackage

// File: rtl/reg_writeback_load_align.sv
// -----------------------------------------------------------------------------
// load_align
//   Extracts and extends load data from a 32-bit little-endian memory word.
//   Ports:
//     word   in  32  data-memory read word
//     funct3 in   3  load type (LB/LH/LW/LBU/LHU)
//     addr   in   2  byte offset of the load address
//     value  out 32  aligned, sign/zero-extended load result
//     valid  out  1  funct3 is a legal load encoding
// -----------------------------------------------------------------------------
module load_align
    import reg_writeback_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    output logic [31:0] value,
    output logic        valid
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case statements can infer a latch.
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        value    = 32'h0000_0000;
        valid    = 1'b0;

        case (addr)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase

        // Halfword loads use only addr[1]; addr[0] is deliberately ignored.
        half_sel = addr[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_LB: begin
                value = {{24{byte_sel[7]}}, byte_sel};
                valid = 1'b1;
            end
            F3_LH: begin
                value = {{16{half_sel[15]}}, half_sel};
                valid = 1'b1;
            end
            F3_LW: begin
                value = word;
                valid = 1'b1;
            end
            F3_LBU: begin
                value = {24'h000000, byte_sel};
                valid = 1'b1;
            end
            F3_LHU: begin
                value = {16'h0000, half_sel};
                valid = 1'b1;
            end
            default: begin
                value = 32'h0000_0000;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/reg_writeback.sv
// -----------------------------------------------------------------------------
// reg_writeback
//   Writeback pipeline register plus register-file write decode and
//   writeback-to-decode forwarding detection.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     stall               hold the writeback register
//     flush               load a bubble (overrides stall)
//     x_valid/x_inst/x_pc/x_alu   execute-stage instruction
//     dmem_dout           synchronous data-memory word for the WB-stage load
//     dec_inst            decode-stage instruction (rs1/rs2 compare)
//     we, wa, wd          register-file write port
//     wb2d_a, wb2d_b      forward wd to decode rs1 / rs2
//     wb_val              forwarding value (== wd)
//   Build option:
//     WB_INSTRET_EN       adds output instret[31:0], a retired-instruction
//                         counter of unstalled, unflushed valid captures.
// -----------------------------------------------------------------------------
module reg_writeback
    import reg_writeback_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        x_valid,
    input  logic [31:0] x_inst,
    input  logic [31:0] x_pc,
    input  logic [31:0] x_alu,
    input  logic [31:0] dmem_dout,
    input  logic [31:0] dec_inst,
    output logic        we,
    output logic [4:0]  wa,
    output logic [31:0] wd,
    output logic        wb2d_a,
    output logic        wb2d_b,
    output logic [31:0] wb_val
`ifdef WB_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    wb_reg_t     w;
    wd_sel_e     wd_sel;
    logic [31:0] load_value;
    logic        load_ok;

    // Writeback register. A flush only kills valid; the remaining fields are
    // don't-care for a bubble and are left as they were.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            w <= '0;
        end else if (flush) begin
            w.valid <= 1'b0;
        end else if (!stall) begin
            w.valid <= x_valid;
            w.inst  <= x_inst;
            w.pc    <= x_pc;
            w.alu   <= x_alu;
        end
    end

    load_align u_load_align (
        .word   (dmem_dout),
        .funct3 (w.inst[14:12]),
        .addr   (w.alu[1:0]),
        .value  (load_value),
        .valid  (load_ok)
    );

    always_comb begin
        wd_sel = WD_NONE;
        case (w.inst[6:0])
            OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OPIMM: wd_sel = WD_ALU;
            OPC_JAL, OPC_JALR:                     wd_sel = WD_PC4;
            OPC_LOAD: wd_sel = load_ok ? WD_LOAD : WD_NONE;
            default:                               wd_sel = WD_NONE;
        endcase
    end

    always_comb begin
        wd = 32'h0000_0000;
        case (wd_sel)
            WD_ALU:  wd = w.alu;
            WD_PC4:  wd = w.pc + 32'd4;   // wraps modulo 2^32
            WD_LOAD: wd = load_value;
            default: wd = 32'h0000_0000;
        endcase
    end

    // Stalled cycles keep we high; rewriting the same value is harmless.
    assign wa     = w.inst[11:7];
    assign we     = w.valid && (wd_sel != WD_NONE) && (wa != 5'd0);
    assign wb_val = wd;
    assign wb2d_a = we && (wa == dec_inst[19:15]);
    assign wb2d_b = we && (wa == dec_inst[24:20]);

`ifdef WB_INSTRET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= 32'h0000_0000;
        end else if (x_valid && !stall && !flush) begin
            instret <= instret + 32'd1;
        end
    end
`endif

    // Instruction bits not consumed by writeback, gathered into one sink.
    logic unused_bits;
    assign unused_bits = ^{w.inst[31:15], dec_inst[31:25], dec_inst[14:0]};

endmodule

// File: tb/tb_reg_writeback.sv
// -----------------------------------------------------------------------------
// tb_reg_writeback
//   Self-checking bench for reg_writeback. A bench-side shadow of the
//   writeback register feeds an independent reference model; expectations are
//   queued when stimulus is driven and compared after the capture edge.
// -----------------------------------------------------------------------------
module tb_reg_writeback;

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        chk_wd;
        logic        fa;
        logic        fb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, x_valid;
    logic [31:0] x_inst, x_pc, x_alu, dmem_dout, dec_inst;
    logic        we, wb2d_a, wb2d_b;
    logic [4:0]  wa;
    logic [31:0] wd, wb_val;
`ifdef WB_INSTRET_EN
    logic [31:0] instret;
`endif

    int n_checks = 0;
    int n_errors = 0;

    exp_t        sb_q[$];
    logic        sh_v;
    logic [31:0] sh_inst, sh_pc, sh_alu;
    logic [31:0] ref_instret;

    always #5 clk = ~clk;

    reg_writeback dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .x_valid   (x_valid),
        .x_inst    (x_inst),
        .x_pc      (x_pc),
        .x_alu     (x_alu),
        .dmem_dout (dmem_dout),
        .dec_inst  (dec_inst),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .wb2d_a    (wb2d_a),
        .wb2d_b    (wb2d_b),
        .wb_val    (wb_val)
`ifdef WB_INSTRET_EN
        ,
        .instret   (instret)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: RV32 writeback from the shadow WB register contents.
    function automatic exp_t model(input logic v, input logic [31:0] inst, pc, alu,
                                   input logic [31:0] dmem, dec);
        exp_t        e;
        logic        wr;
        logic [31:0] data;
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        wr   = 1'b0;
        data = 32'h0;
        sh   = dmem >> (8 * alu[1:0]);
        b    = sh[7:0];
        sh   = dmem >> (16 * alu[1]);
        h    = sh[15:0];
        case (inst[6:0])
            7'h37, 7'h17, 7'h33, 7'h13: begin wr = 1'b1; data = alu; end
            7'h6F, 7'h67:               begin wr = 1'b1; data = pc + 32'd4; end
            7'h03: begin
                wr = 1'b1;
                case (inst[14:12])
                    3'd0: data = 32'($signed(b));
                    3'd1: data = 32'($signed(h));
                    3'd2: data = dmem;
                    3'd4: data = {24'd0, b};
                    3'd5: data = {16'd0, h};
                    default: wr = 1'b0;
                endcase
            end
            default: wr = 1'b0;
        endcase
        e.wa     = inst[11:7];
        e.we     = v & wr & (inst[11:7] != 5'd0);
        e.wd     = data;
        e.chk_wd = wr;
        e.fa     = e.we & (inst[11:7] == dec[19:15]);
        e.fb     = e.we & (inst[11:7] == dec[24:20]);
        return e;
    endfunction

    // One pipeline cycle: drive execute inputs, predict the WB register after
    // the edge, queue the expectation, then compare once outputs settle.
    task automatic step(input logic v, input logic [31:0] inst, pc, alu,
                        input logic st, fl, input logic [31:0] dmem, dec,
                        input string tag);
        exp_t e;
        x_valid = v; x_inst = inst; x_pc = pc; x_alu = alu;
        stall = st;  flush = fl;
        if (fl) begin
            sh_v = 1'b0;
        end else if (!st) begin
            sh_v = v; sh_inst = inst; sh_pc = pc; sh_alu = alu;
        end
        sb_q.push_back(model(sh_v, sh_inst, sh_pc, sh_alu, dmem, dec));
        @(posedge clk);
        if (v && !st && !fl) ref_instret = ref_instret + 32'd1;
        #1;
        dmem_dout = dmem;
        dec_inst  = dec;
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_we"}, {31'd0, we}, {31'd0, e.we});
            check({tag, "_wa"}, {27'd0, wa}, {27'd0, e.wa});
            if (e.chk_wd) check({tag, "_wd"}, wd, e.wd);
            check({tag, "_fa"}, {31'd0, wb2d_a}, {31'd0, e.fa});
            check({tag, "_fb"}, {31'd0, wb2d_b}, {31'd0, e.fb});
            check({tag, "_wbval"}, wb_val, wd);
        end
    endtask

    localparam logic [31:0] ADDI_X5  = 32'h0000_0293;
    localparam logic [31:0] LB_X6    = 32'h0000_0303;
    localparam logic [31:0] LBU_X6   = 32'h0000_4303;
    localparam logic [31:0] LH_X6    = 32'h0000_1303;
    localparam logic [31:0] LHU_X6   = 32'h0000_5303;
    localparam logic [31:0] LW_X8    = 32'h0000_2403;
    localparam logic [31:0] LD_X6    = 32'h0000_3303;   // funct3 011
    localparam logic [31:0] JAL_X1   = 32'h0000_00EF;
    localparam logic [31:0] JALR_X1  = 32'h0000_00E7;
    localparam logic [31:0] LUI_X2   = 32'h0000_0137;
    localparam logic [31:0] SW_RD4   = 32'h0000_0223;   // store, rd field 4
    localparam logic [31:0] ADDI_X0  = 32'h0000_0013;
    localparam logic [31:0] ADDI_X7  = 32'h0000_0393;
    localparam logic [31:0] ADDI_X9  = 32'h0000_0493;
    localparam logic [31:0] ADDI_X10 = 32'h0000_0513;
    localparam logic [31:0] DEC_R7R7 = 32'h0073_8000;

    initial begin
        logic [6:0]  opcs [6];
        logic [31:0] ri;
        opcs = '{7'h37, 7'h17, 7'h33, 7'h13, 7'h6F, 7'h67};

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; x_valid = 1'b0;
        x_inst = '0; x_pc = '0; x_alu = '0; dmem_dout = '0; dec_inst = '0;
        sh_v = 1'b0; sh_inst = '0; sh_pc = '0; sh_alu = '0; ref_instret = '0;

        // Reset state.
        #3;
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_wa", {27'd0, wa}, 32'd0);
        check("rst_wd", wd, 32'd0);
        check("rst_fa", {31'd0, wb2d_a}, 32'd0);
        check("rst_fb", {31'd0, wb2d_b}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        step(1'b1, ADDI_X5, 32'h100, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0, "addi");
        check("addi_wd_const", wd, 32'h0000_1234);
        step(1'b1, LB_X6,  32'h104, 32'h1003, 1'b0, 1'b0, 32'h80FF_0000, 32'h0, "lb");
        check("lb_wd_const", wd, 32'hFFFF_FF80);
        step(1'b1, LBU_X6, 32'h108, 32'h1003, 1'b0, 1'b0, 32'h80FF_0000, 32'h0, "lbu");
        check("lbu_wd_const", wd, 32'h0000_0080);
        step(1'b1, LH_X6,  32'h10C, 32'h1003, 1'b0, 1'b0, 32'h80FF_0000, 32'h0, "lh_odd");
        check("lh_wd_const", wd, 32'hFFFF_80FF);
        step(1'b1, LHU_X6, 32'h110, 32'h1000, 1'b0, 1'b0, 32'h80FF_8001, 32'h0, "lhu");
        check("lhu_wd_const", wd, 32'h0000_8001);
        step(1'b1, LD_X6,  32'h114, 32'h1000, 1'b0, 1'b0, 32'h1234_5678, 32'h0, "ld_bad");
        check("ld_bad_we", {31'd0, we}, 32'd0);
        step(1'b1, JAL_X1, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, "jal_wrap");
        check("jal_wd_const", wd, 32'h0000_0000);
        check("jal_we_const", {31'd0, we}, 32'd1);
        step(1'b1, JALR_X1, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, "jalr");
        step(1'b1, LUI_X2, 32'h0, 32'hABCD_E000, 1'b0, 1'b0, 32'h0, 32'h0, "lui");
        step(1'b1, SW_RD4, 32'h0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, "store");
        step(1'b1, ADDI_X0, 32'h0, 32'h5, 1'b0, 1'b0, 32'h0, 32'h0, "addi_x0");
        check("x0_fa_const", {31'd0, wb2d_a}, 32'd0);

        // Forwarding, then stall+flush on the same edge.
        step(1'b1, ADDI_X7, 32'h0, 32'h55, 1'b0, 1'b0, 32'h0, DEC_R7R7, "fwd_x7");
        check("fwd_a_const", {31'd0, wb2d_a}, 32'd1);
        check("fwd_b_const", {31'd0, wb2d_b}, 32'd1);
        step(1'b1, ADDI_X9, 32'h0, 32'h99, 1'b1, 1'b1, 32'h0, DEC_R7R7, "stall_flush");
        check("stall_flush_we", {31'd0, we}, 32'd0);

        // Stall holds the write and keeps we asserted.
        step(1'b1, ADDI_X10, 32'h0, 32'h77, 1'b0, 1'b0, 32'h0, 32'h0, "pre_stall");
        step(1'b1, ADDI_X9,  32'h0, 32'h99, 1'b1, 1'b0, 32'h0, 32'h0, "stall1");
        step(1'b0, 32'h0,    32'h0, 32'h0,  1'b1, 1'b0, 32'h0, 32'h0, "stall2");
        check("stall_wd_const", wd, 32'h0000_0077);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0, "flush_only");

        // Randomised ALU/jump and load traffic against the model.
        for (int i = 0; i < 40; i++) begin
            ri = $urandom;
            if (i % 2 == 0) begin
                ri[6:0] = opcs[$urandom_range(0, 5)];
            end else begin
                ri[6:0] = 7'h03;
            end
            step(1'($urandom_range(0, 3) != 0), ri, $urandom, $urandom,
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 6) == 0),
                 $urandom, (i % 3 == 0) ? {7'd0, ri[11:7], ri[11:7], 15'd0} : $urandom,
                 "rnd");
        end

`ifdef WB_INSTRET_EN
        check("instret_count", instret, ref_instret);
`endif

        // Reset asserted mid-stall with a valid LW held in writeback.
        step(1'b1, LW_X8, 32'h200, 32'h2000, 1'b0, 1'b0, 32'h1122_3344, 32'h0, "lw");
        step(1'b1, LW_X8, 32'h200, 32'h2000, 1'b1, 1'b0, 32'h1122_3344, 32'h0, "lw_stall");
        check("lw_held_we", {31'd0, we}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        sh_v = 1'b0; sh_inst = '0; sh_pc = '0; sh_alu = '0; ref_instret = '0;
        check("rst_mid_we", {31'd0, we}, 32'd0);
        check("rst_mid_wa", {27'd0, wa}, 32'd0);
        check("rst_mid_fa", {31'd0, wb2d_a}, 32'd0);
`ifdef WB_INSTRET_EN
        check("rst_mid_instret", instret, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, LW_X8, 32'h200, 32'h2000, 1'b0, 1'b0, 32'h1122_3344, 32'h0, "post_rst");
        step(1'b1, LW_X8, 32'h200, 32'h2000, 1'b0, 1'b0, 32'h1122_3344, 32'h0, "fresh_lw");
        check("fresh_lw_wd", wd, 32'h1122_3344);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
